// File: rtl/bitwise_serial_unit_pkg.sv
// Shared encodings for the bit-serial bitwise unit: operation codes, FSM states
// and the single-bit operation function.
package bitwise_serial_unit_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_HOLD  = 2'b10
    } state_e;

    function automatic logic op_apply(input op_e op, input logic x, input logic y);
        logic f;
        case (op)
            OP_OR:   f = x | y;
            OP_AND:  f = x & y;
            OP_XOR:  f = x ^ y;
            OP_NOR:  f = ~(x | y);
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bitwise_serial_unit_if.sv
// Serial operand input, parallel result output and control handshake of the
// bit-serial bitwise unit. The master side is the operand source/result consumer.
interface bitwise_serial_unit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic             x_bit;
    logic             y_bit;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, op, in_valid, x_bit, y_bit, out_ready,
        input  in_ready, result, out_valid, busy
    );

    modport slave (
        input  start, op, in_valid, x_bit, y_bit, out_ready,
        output in_ready, result, out_valid, busy
    );
endinterface

// File: rtl/bitwise_serial_unit_op_cell.sv
// Combinational single-bit gate: applies the selected bitwise op to one bit pair.
module bitwise_op_cell
    import bitwise_serial_unit_pkg::*;
(
    input  logic [1:0] op_i,
    input  logic       x_i,
    input  logic       y_i,
    output logic       f_o
);

    always_comb begin
        f_o = op_apply(op_e'(op_i), x_i, y_i);
    end

endmodule

// File: rtl/bitwise_serial_unit.sv
// Bit-serial bitwise unit: collects WIDTH bit pairs LSB first, applies the
// latched op per bit and holds the parallel result under a valid/ready handshake.
module bitwise_serial_unit
    import bitwise_serial_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bitwise_serial_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               f_bit;
    logic               accept;
    logic               consume;

    bitwise_op_cell u_op_cell (
        .op_i (op_q),
        .x_i  (bus.x_bit),
        .y_i  (bus.y_bit),
        .f_o  (f_bit)
    );

    // A start in SHIFT wins over a same-cycle bit pair, so it blocks accept.
    assign accept  = (state_q == S_SHIFT) && bus.in_valid && !bus.start;
    assign consume = (state_q == S_HOLD) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_OR;
            count_q  <= '0;
            sreg_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            sreg_q   <= sreg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SHIFT;
            S_SHIFT: if (accept && count_q == LAST_IDX) state_d = S_HOLD;
            S_HOLD:  if (consume) state_d = bus.start ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        count_d  = count_q;
        sreg_d   = sreg_q;
        result_d = result_q;
        if ((bus.start && state_q != S_HOLD) || (bus.start && consume)) begin
            op_d    = op_e'(bus.op);
            count_d = '0;
            sreg_d  = '0;
        end else if (accept) begin
            sreg_d[count_q] = f_bit;
            if (count_q == LAST_IDX) begin
                result_d = sreg_d;
                count_d  = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == S_SHIFT);
        bus.out_valid = (state_q == S_HOLD);
        bus.busy      = (state_q != S_IDLE);
        bus.result    = result_q;
    end

endmodule

// File: tb/tb_bitwise_serial_unit.sv
// Directed bench for bitwise_serial_unit: op frames, stalls, abort, HOLD starts, reset.
module tb_bitwise_serial_unit;

    localparam int unsigned WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bitwise_serial_unit_if #(.WIDTH(WIDTH)) bus ();

    bitwise_serial_unit #(.WIDTH(WIDTH), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] op);
        bus.start = 1'b1;
        bus.op    = op;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic x, input logic y);
        bus.in_valid = 1'b1;
        bus.x_bit    = x;
        bus.y_bit    = y;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    // Full back-to-back frame with the result checked on the HOLD entry cycle.
    task automatic run_frame(input string tag, input logic [1:0] op,
                             input logic [3:0] x, input logic [3:0] y,
                             input logic [3:0] exp);
        do_start(op);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.x_bit    = x[i];
            bus.y_bit    = y[i];
            if (i == 3) chk({tag, "_ov_early"}, 32'(bus.out_valid), 32'd0);
            cyc();
        end
        bus.in_valid = 1'b0;
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_result"}, 32'(bus.result), 32'(exp));
        consume();
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_result_kept"}, 32'(bus.result), 32'(exp));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.in_valid  = 1'b0;
        bus.x_bit     = 1'b0;
        bus.y_bit     = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // in_valid in IDLE is ignored
        send_bit(1'b1, 1'b1);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

        run_frame("or",  2'b00, 4'b1010, 4'b0101, 4'b1111);
        run_frame("and", 2'b01, 4'b1100, 4'b1010, 4'b1000);
        run_frame("xor", 2'b10, 4'b1100, 4'b1010, 4'b0110);
        run_frame("nor", 2'b11, 4'b1100, 4'b1010, 4'b0001);

        // Gapped input (1 on, 2 off), OR x=0011 y=0100, op input changed mid-frame
        do_start(2'b00);
        bus.op = 2'b11;
        for (int i = 0; i < 4; i++) begin
            send_bit(4'(4'b0011 >> i) & 1'b1, 4'(4'b0100 >> i) & 1'b1);
            if (i < 3) begin
                cyc();
                cyc();
                chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
                chk("gap_out_valid", 32'(bus.out_valid), 32'd0);
            end
        end
        chk("gap_out_valid_end", 32'(bus.out_valid), 32'd1);
        chk("gap_result", 32'(bus.result), 32'h7);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", 32'(bus.result), 32'h7);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        consume();
        chk("hold_released", 32'(bus.out_valid), 32'd0);

        // Abort after two bits; the pair arriving with start is dropped
        do_start(2'b00);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.in_valid = 1'b1;
        bus.x_bit    = 1'b1;
        bus.y_bit    = 1'b1;
        cyc();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("abort_ov_early", 32'(bus.out_valid), 32'd0);
        send_bit(1'b1, 1'b1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd1);
        chk("abort_result", 32'(bus.result), 32'h9);

        // start alone in HOLD is ignored
        do_start(2'b10);
        chk("hold_start_ov", 32'(bus.out_valid), 32'd1);
        chk("hold_start_ir", 32'(bus.in_ready), 32'd0);
        cyc();
        chk("hold_start_not_queued", 32'(bus.out_valid), 32'd1);

        // start together with out_ready goes straight to SHIFT
        bus.start     = 1'b1;
        bus.op        = 2'b10;
        bus.out_ready = 1'b1;
        cyc();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        chk("hs_start_busy", 32'(bus.busy), 32'd1);
        chk("hs_start_ir", 32'(bus.in_ready), 32'd1);
        chk("hs_start_ov", 32'(bus.out_valid), 32'd0);

        // Reset after three bits loses everything
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_result", 32'(bus.result), 32'd0);
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ir", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("post_rst_ignored_ir", 32'(bus.in_ready), 32'd0);
        chk("post_rst_ignored_ov", 32'(bus.out_valid), 32'd0);

        run_frame("post_rst", 2'b10, 4'b1100, 4'b1010, 4'b0110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
